lmc_microwire_rx: RTL and testbench
===================================

Name: lmc_microwire_rx

Overview:
- Receive-side endpoint of the STE microwire bus: a functional model of the LMC1992 volume/tone controller.
- Deserialises microwire frames sent by the shifter's microwire master and decodes LMC1992 commands into control registers.
- Applies master and left/right attenuation to the DMA-sound samples.
- Sits between the shifter's audio outputs and the board audio mixer, on clk32.

Parameters:
- ADDR, 2'b10, device address that a frame must carry to be accepted.
- OUT_W, 16, width of each signed audio output.

Ports:
- clk32  in  1  system clock
- resb  in  1  asynchronous reset, active low
- mw_clk  in  1  microwire serial clock; a rising edge samples mw_data
- mw_data  in  1  microwire serial data, MSB first
- mw_en  in  1  frame enable; high for the duration of a transfer
- smp_stb  in  1  one-cycle strobe: new sample present on audio_in_*
- audio_in_l  in  8  left sample, offset binary (0x80 = silence)
- audio_in_r  in  8  right sample, offset binary
- audio_out_l  out  OUT_W  attenuated left sample, signed
- audio_out_r  out  OUT_W  attenuated right sample, signed
- out_stb  out  1  one-cycle strobe: audio_out_* updated
- master_vol  out  6  0..40, 2 dB steps, 40 = 0 dB
- left_vol  out  5  0..20, 2 dB steps
- right_vol  out  5  0..20, 2 dB steps
- bass  out  4  0..12, 6 = flat
- treble  out  4  0..12, 6 = flat
- mixer  out  2  input mixer select
- cmd_stb  out  1  one-cycle pulse: a command was accepted

Behaviour:
- Reset values: master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mixer=2'b01, audio_out_*=0, out_stb=0, cmd_stb=0. The bit counter and shift register are cleared.
- Edge detect: mw_clk_d, mw_en_d registered. A rise of mw_clk while mw_en=1 shifts mw_data into an 11-bit shift register (sr <= {sr[9:0], mw_data}) and increments a 5-bit counter, which saturates at 31.
- A rise of mw_clk while mw_en=0 is ignored.
- A rise of mw_en clears the counter. Frames are back-to-back capable.
- Frame end is the fall of mw_en. The frame is accepted iff count >= 11 and sr[10:9] == ADDR. Only the last 11 bits received are decoded. Otherwise the frame is silently discarded.
- Decode on acceptance (sr[8:6] = function, sr[5:0] = data). Registers update on the cycle after the mw_en fall; cmd_stb pulses in that same cycle.
  - 000: mixer <= data[1:0]
  - 001: bass <= min(data[3:0], 12)
  - 010: treble <= min(data[3:0], 12)
  - 011: master_vol <= min(data, 40)
  - 100: right_vol <= min(data[4:0], 20)
  - 101: left_vol <= min(data[4:0], 20)
  - 110/111: no register change, no cmd_stb
- A fall of mw_en in the same cycle as a mw_clk rise: the bit is captured first, then the frame is evaluated.
- Gain pipeline, two cycles, per channel:
  - S0 (on smp_stb): s = audio_in ^ 8'h80 (signed). n = (40 - master_vol) + (20 - chan_vol), range 0..60. shift = n / 3. frac = LUT[n % 3] = {256, 203, 161}. s, shift and frac are registered.
  - S1: p = s * frac (signed 17-bit). audio_out = p >>> shift (arithmetic). If shift > 15, audio_out = 0. out_stb pulses.
- Latency: out_stb fires exactly 2 cycles after smp_stb. A smp_stb every cycle is supported at full throughput.
- Simultaneous register update and smp_stb: S0 uses the pre-update register values.
- Reset mid-frame or mid-pipeline: everything returns to reset values immediately; the partial frame is lost.

Optional Feature:
- LMC_MW_SYNC_EN
  - Defined: mw_clk, mw_data and mw_en pass through 2-flop synchronisers before edge detection. This adds 2 cycles to decode latency and is for an asynchronous microwire source.
  - Undefined: the inputs are treated as clk32-synchronous and sampled directly.

Decomposition:
- Package lmc_pkg holds:
  - function codes (FN_MIXER..FN_LEFT)
  - reset values
  - clamp maxima (40, 20, 12)
  - frac LUT constants 256/203/161
  - default ADDR
- Natural sub-module: lmc_gain (S0/S1 datapath, one channel), instantiated twice.

Test Plan:
- Frame 11'h4E8 (master=40), then 11'h554 (left=20) -> registers are 40/20, cmd_stb pulses twice; smp_stb with audio_in_l=0xFF -> audio_out_l=32512 two cycles later.
- Master frame with data 37 -> n=3; audio_in_l=0xFF -> 16256; audio_in_l=0x80 -> 0; master data 39 -> n=1, 0xFF -> 25781.
- Master data 63 -> clamped 40; bass data 15 -> clamped 12; function 3'b111 -> no change, no cmd_stb.
- Wrong address 2'b01, or only 10 bits in the frame -> no register change; 13-bit frame whose last 11 bits are 11'h554 -> left_vol=20 accepted.
- master=0, left=0 -> n=60, shift=20 -> audio_out_l=0 for any input; audio_in_l=0x00 with n=0 -> -32768.
- resb low mid-frame after 6 bits -> all outputs at reset values; the next complete frame decodes correctly.

Source files
------------

// File: rtl/lmc_pkg.sv
// Shared constants for the LMC1992 microwire receiver: function codes,
// reset values, clamp limits and the fractional gain table.
`timescale 1ns/1ps
package lmc_pkg;

    localparam logic [1:0] ADDR_DEF = 2'b10;

    typedef enum logic [2:0] {
        FN_MIXER  = 3'd0,
        FN_BASS   = 3'd1,
        FN_TREBLE = 3'd2,
        FN_MASTER = 3'd3,
        FN_RIGHT  = 3'd4,
        FN_LEFT   = 3'd5
    } lmc_fn_e;

    localparam logic [5:0] MASTER_MAX = 6'd40;
    localparam logic [4:0] CHAN_MAX   = 5'd20;
    localparam logic [3:0] TONE_MAX   = 4'd12;

    localparam logic [5:0] MASTER_RST = 6'd40;
    localparam logic [4:0] CHAN_RST   = 5'd20;
    localparam logic [3:0] TONE_RST   = 4'd6;
    localparam logic [1:0] MIXER_RST  = 2'b01;

    localparam logic [8:0] FRAC0 = 9'd256;
    localparam logic [8:0] FRAC1 = 9'd203;
    localparam logic [8:0] FRAC2 = 9'd161;

    // 2 dB steps: every 3 steps is one power of two, remainder is a fraction
    function automatic logic [8:0] frac_lut(input logic [1:0] idx);
        case (idx)
            2'd1:    frac_lut = FRAC1;
            2'd2:    frac_lut = FRAC2;
            default: frac_lut = FRAC0;
        endcase
    endfunction

endpackage

// File: rtl/lmc_gain.sv
// One channel of the attenuation datapath: S0 converts the sample and
// splits the attenuation into shift/fraction, S1 multiplies and shifts.
`timescale 1ns/1ps
module lmc_gain
    import lmc_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stb_i,
    input  logic [7:0]              smp_i,
    input  logic [5:0]              master_i,
    input  logic [4:0]              chan_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    stb_o
);

    logic [6:0]              n_w;
    logic [4:0]              sh_d;
    logic [1:0]              rem_d;
    logic signed [7:0]       s_d;
    logic signed [7:0]       s_q;
    logic [4:0]              sh_q;
    logic [8:0]              frac_q;
    logic                    vld_q;
    logic signed [16:0]      p_w;
    logic signed [16:0]      sr_w;
    logic signed [OUT_W-1:0] out_d;
    logic signed [OUT_W-1:0] out_q;
    logic                    stb_q;

    assign n_w   = (7'(MASTER_MAX) - {1'b0, master_i})
                 + (7'(CHAN_MAX) - {2'b00, chan_i});
    assign sh_d  = 5'(n_w / 7'd3);
    assign rem_d = 2'(n_w % 7'd3);
    assign s_d   = smp_i ^ 8'h80;

    assign p_w   = s_q * $signed({1'b0, frac_q});
    assign sr_w  = p_w >>> sh_q;
    assign out_d = (sh_q > 5'd15) ? '0 : OUT_W'(sr_w);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_q    <= '0;
            sh_q   <= '0;
            frac_q <= FRAC0;
            vld_q  <= 1'b0;
            out_q  <= '0;
            stb_q  <= 1'b0;
        end else begin
            vld_q <= stb_i;
            stb_q <= vld_q;
            if (stb_i) begin
                s_q    <= s_d;
                sh_q   <= sh_d;
                frac_q <= frac_lut(rem_d);
            end
            if (vld_q) begin
                out_q <= out_d;
            end
        end
    end

    assign out_o = out_q;
    assign stb_o = stb_q;

endmodule

// File: rtl/lmc_microwire_rx.sv
// LMC1992 microwire receiver: frame capture, command decode, L/R gain.
// Define LMC_MW_SYNC_EN to add 2-flop synchronisers on the microwire pins.
`timescale 1ns/1ps
module lmc_microwire_rx
    import lmc_pkg::*;
#(
    parameter logic [1:0] ADDR  = ADDR_DEF,
    parameter int         OUT_W = 16
) (
    input  logic                    clk32,
    input  logic                    resb,
    input  logic                    mw_clk,
    input  logic                    mw_data,
    input  logic                    mw_en,
    input  logic                    smp_stb,
    input  logic [7:0]              audio_in_l,
    input  logic [7:0]              audio_in_r,
    output logic signed [OUT_W-1:0] audio_out_l,
    output logic signed [OUT_W-1:0] audio_out_r,
    output logic                    out_stb,
    output logic [5:0]              master_vol,
    output logic [4:0]              left_vol,
    output logic [4:0]              right_vol,
    output logic [3:0]              bass,
    output logic [3:0]              treble,
    output logic [1:0]              mixer,
    output logic                    cmd_stb
);

    logic mw_clk_w;
    logic mw_dat_w;
    logic mw_en_w;

`ifdef LMC_MW_SYNC_EN
    logic [1:0] clk_s_q;
    logic [1:0] dat_s_q;
    logic [1:0] en_s_q;

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            clk_s_q <= '0;
            dat_s_q <= '0;
            en_s_q  <= '0;
        end else begin
            clk_s_q <= {clk_s_q[0], mw_clk};
            dat_s_q <= {dat_s_q[0], mw_data};
            en_s_q  <= {en_s_q[0], mw_en};
        end
    end

    assign mw_clk_w = clk_s_q[1];
    assign mw_dat_w = dat_s_q[1];
    assign mw_en_w  = en_s_q[1];
`else
    assign mw_clk_w = mw_clk;
    assign mw_dat_w = mw_data;
    assign mw_en_w  = mw_en;
`endif

    logic        mw_clk_d_q;
    logic        mw_en_d_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [10:0] sr_q;
    logic [10:0] sr_d;
    logic        clk_rise;
    logic        en_rise;
    logic        en_fall;
    logic        shift_en;
    logic        accept;
    logic [2:0]  fn;
    logic [5:0]  data;

    logic [5:0]  master_q;
    logic [4:0]  left_q;
    logic [4:0]  right_q;
    logic [3:0]  bass_q;
    logic [3:0]  treble_q;
    logic [1:0]  mixer_q;
    logic        cmd_stb_q;

    assign clk_rise = mw_clk_w & ~mw_clk_d_q;
    assign en_rise  = mw_en_w & ~mw_en_d_q;
    assign en_fall  = ~mw_en_w & mw_en_d_q;
    // a clock edge coinciding with the enable fall still belongs to the frame
    assign shift_en = clk_rise & (mw_en_w | en_fall);

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (en_rise) begin
            cnt_d = '0;
        end
        if (shift_en) begin
            sr_d = {sr_q[9:0], mw_dat_w};
            if (cnt_d != 5'd31) begin
                cnt_d = cnt_d + 5'd1;
            end
        end
    end

    assign accept = en_fall && (cnt_d >= 5'd11) && (sr_d[10:9] == ADDR);
    assign fn     = sr_d[8:6];
    assign data   = sr_d[5:0];

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            mw_clk_d_q <= 1'b0;
            mw_en_d_q  <= 1'b0;
            cnt_q      <= '0;
            sr_q       <= '0;
            master_q   <= MASTER_RST;
            left_q     <= CHAN_RST;
            right_q    <= CHAN_RST;
            bass_q     <= TONE_RST;
            treble_q   <= TONE_RST;
            mixer_q    <= MIXER_RST;
            cmd_stb_q  <= 1'b0;
        end else begin
            mw_clk_d_q <= mw_clk_w;
            mw_en_d_q  <= mw_en_w;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            cmd_stb_q  <= 1'b0;
            if (accept) begin
                case (fn)
                    FN_MIXER: begin
                        mixer_q   <= data[1:0];
                        cmd_stb_q <= 1'b1;
                    end
                    FN_BASS: begin
                        bass_q    <= (data[3:0] > TONE_MAX) ? TONE_MAX : data[3:0];
                        cmd_stb_q <= 1'b1;
                    end
                    FN_TREBLE: begin
                        treble_q  <= (data[3:0] > TONE_MAX) ? TONE_MAX : data[3:0];
                        cmd_stb_q <= 1'b1;
                    end
                    FN_MASTER: begin
                        master_q  <= (data > MASTER_MAX) ? MASTER_MAX : data;
                        cmd_stb_q <= 1'b1;
                    end
                    FN_RIGHT: begin
                        right_q   <= (data[4:0] > CHAN_MAX) ? CHAN_MAX : data[4:0];
                        cmd_stb_q <= 1'b1;
                    end
                    FN_LEFT: begin
                        left_q    <= (data[4:0] > CHAN_MAX) ? CHAN_MAX : data[4:0];
                        cmd_stb_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    logic stb_l;
    logic stb_r;

    lmc_gain #(.OUT_W(OUT_W)) u_gain_l (
        .clk_i   (clk32),
        .rst_ni  (resb),
        .stb_i   (smp_stb),
        .smp_i   (audio_in_l),
        .master_i(master_q),
        .chan_i  (left_q),
        .out_o   (audio_out_l),
        .stb_o   (stb_l)
    );

    lmc_gain #(.OUT_W(OUT_W)) u_gain_r (
        .clk_i   (clk32),
        .rst_ni  (resb),
        .stb_i   (smp_stb),
        .smp_i   (audio_in_r),
        .master_i(master_q),
        .chan_i  (right_q),
        .out_o   (audio_out_r),
        .stb_o   (stb_r)
    );

    assign out_stb    = stb_l & stb_r;
    assign master_vol = master_q;
    assign left_vol   = left_q;
    assign right_vol  = right_q;
    assign bass       = bass_q;
    assign treble     = treble_q;
    assign mixer      = mixer_q;
    assign cmd_stb    = cmd_stb_q;

endmodule

// File: tb/tb_lmc_microwire_rx.sv
// Directed and random stimulus for lmc_microwire_rx against a
// register-level reference model of the LMC1992 command set and gain law.
`timescale 1ns/1ps
module tb_lmc_microwire_rx;

    logic        clk32 = 1'b0;
    logic        resb = 1'b0;
    logic        mw_clk = 1'b0;
    logic        mw_data = 1'b0;
    logic        mw_en = 1'b0;
    logic        smp_stb = 1'b0;
    logic [7:0]  audio_in_l = 8'h80;
    logic [7:0]  audio_in_r = 8'h80;
    logic signed [15:0] audio_out_l;
    logic signed [15:0] audio_out_r;
    logic        out_stb;
    logic [5:0]  master_vol;
    logic [4:0]  left_vol;
    logic [4:0]  right_vol;
    logic [3:0]  bass;
    logic [3:0]  treble;
    logic [1:0]  mixer;
    logic        cmd_stb;

    lmc_microwire_rx dut (
        .clk32      (clk32),
        .resb       (resb),
        .mw_clk     (mw_clk),
        .mw_data    (mw_data),
        .mw_en      (mw_en),
        .smp_stb    (smp_stb),
        .audio_in_l (audio_in_l),
        .audio_in_r (audio_in_r),
        .audio_out_l(audio_out_l),
        .audio_out_r(audio_out_r),
        .out_stb    (out_stb),
        .master_vol (master_vol),
        .left_vol   (left_vol),
        .right_vol  (right_vol),
        .bass       (bass),
        .treble     (treble),
        .mixer      (mixer),
        .cmd_stb    (cmd_stb)
    );

    always #5 clk32 = ~clk32;

    int n_assert = 0;
    int n_fail = 0;
    int n_cmd = 0;

    int m_master = 40;
    int m_left = 20;
    int m_right = 20;
    int m_bass = 6;
    int m_treble = 6;
    int m_mixer = 1;

    always @(negedge clk32) begin
        if (cmd_stb === 1'b1) n_cmd++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // attenuation n*2dB = 2^-(n/3) * {1, 0.794, 0.629}; result floored
    function automatic int exp_audio(input int smp, input int mv, input int cv);
        int s, n, sh, f, p, d;
        s = smp - 128;
        n = (40 - mv) + (20 - cv);
        sh = n / 3;
        case (n % 3)
            0: f = 256;
            1: f = 203;
            default: f = 161;
        endcase
        p = s * f;
        if (sh > 15) return 0;
        d = 1 << sh;
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    function automatic bit model_frame(input logic [31:0] val, input int len);
        logic [10:0] w;
        int d;
        if (len < 11) return 1'b0;
        w = val[10:0];
        if (w[10:9] != 2'b10) return 1'b0;
        d = int'(w[5:0]);
        case (int'(w[8:6]))
            0: m_mixer = d % 4;
            1: m_bass = imin(d % 16, 12);
            2: m_treble = imin(d % 16, 12);
            3: m_master = imin(d, 40);
            4: m_right = imin(d % 32, 20);
            5: m_left = imin(d % 32, 20);
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [31:0] mk(input int fn, input int d);
        logic [31:0] v;
        v = 32'd0;
        v[10:9] = 2'b10;
        v[8:6] = 3'(fn);
        v[5:0] = 6'(d);
        return v;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".master"}, master_vol, m_master);
        check({tag, ".left"}, left_vol, m_left);
        check({tag, ".right"}, right_vol, m_right);
        check({tag, ".bass"}, bass, m_bass);
        check({tag, ".treble"}, treble, m_treble);
        check({tag, ".mixer"}, mixer, m_mixer);
    endtask

    task automatic send(input logic [31:0] val, input int len, input bit merge);
        @(negedge clk32);
        mw_en = 1'b1;
        mw_clk = 1'b0;
        @(negedge clk32);
        for (int i = len - 1; i >= 0; i--) begin
            mw_data = val[i];
            mw_clk = 1'b0;
            @(negedge clk32);
            mw_clk = 1'b1;
            if (merge && i == 0) mw_en = 1'b0;
            @(negedge clk32);
        end
        mw_clk = 1'b0;
        mw_en = 1'b0;
        repeat (6) @(negedge clk32);
    endtask

    task automatic frame(input string tag, input logic [31:0] val,
                         input int len, input bit merge);
        int c0;
        bit e;
        c0 = n_cmd;
        e = model_frame(val, len);
        send(val, len, merge);
        check({tag, ".cmd"}, n_cmd - c0, e ? 1 : 0);
        check_regs(tag);
    endtask

    task automatic sample(input string tag, input logic [7:0] l,
                          input logic [7:0] r);
        int el, er;
        el = exp_audio(int'(l), m_master, m_left);
        er = exp_audio(int'(r), m_master, m_right);
        smp_stb = 1'b1;
        audio_in_l = l;
        audio_in_r = r;
        @(negedge clk32);
        smp_stb = 1'b0;
        check({tag, ".stb1"}, out_stb, 0);
        @(negedge clk32);
        check({tag, ".stb2"}, out_stb, 1);
        check({tag, ".l"}, audio_out_l, el);
        check({tag, ".r"}, audio_out_r, er);
        @(negedge clk32);
        check({tag, ".stb3"}, out_stb, 0);
    endtask

    initial begin
        int ql[$];
        int qr[$];
        logic [31:0] v;
        int len;

        repeat (3) @(negedge clk32);
        check_regs("rst");
        check("rst.outl", audio_out_l, 0);
        check("rst.outr", audio_out_r, 0);
        check("rst.ostb", out_stb, 0);
        check("rst.cstb", cmd_stb, 0);
        resb = 1'b1;
        repeat (2) @(negedge clk32);

        frame("f4e8", 32'h4E8, 11, 1'b0);
        frame("f554", 32'h554, 11, 1'b0);
        sample("s0db", 8'hFF, 8'h80);

        frame("m37", mk(3, 37), 11, 1'b0);
        sample("n3ff", 8'hFF, 8'h40);
        sample("n3sil", 8'h80, 8'hC0);
        frame("m39", mk(3, 39), 11, 1'b0);
        sample("n1ff", 8'hFF, 8'h01);

        frame("m63", mk(3, 63), 11, 1'b0);
        frame("b15", mk(1, 15), 11, 1'b0);
        frame("fn7", mk(7, 5), 11, 1'b0);
        frame("fn6", mk(6, 1), 11, 1'b0);

        v = mk(5, 3);
        v[10:9] = 2'b01;
        frame("badaddr", v, 11, 1'b0);
        frame("short", mk(5, 3), 10, 1'b0);
        frame("l5", mk(5, 5), 11, 1'b0);
        frame("long13", {19'd0, 2'b11, 11'h554}, 13, 1'b0);
        frame("merge", mk(4, 7), 11, 1'b1);
        frame("mix2", mk(0, 6), 11, 1'b0);

        frame("m0", mk(3, 0), 11, 1'b0);
        frame("l0", mk(5, 0), 11, 1'b0);
        sample("n60", 8'(($urandom_range(0, 255))), 8'hFF);
        frame("m40", mk(3, 40), 11, 1'b0);
        frame("l20", mk(5, 20), 11, 1'b0);
        sample("neg", 8'h00, 8'h00);

        for (int k = 0; k < 24; k++) begin
            v = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
            if ($urandom_range(0, 4) == 0) v[10:9] = 2'($urandom_range(0, 3));
            len = 11;
            if ($urandom_range(0, 5) == 0) begin
                len = 12;
                v[11] = 1'($urandom_range(0, 1));
            end
            frame("rnd", v, len, 1'($urandom_range(0, 1)));
            sample("rnds", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                check("tp.stb", out_stb, 1);
                check("tp.l", audio_out_l, ql.pop_front());
                check("tp.r", audio_out_r, qr.pop_front());
            end
            if (i < 10) begin
                audio_in_l = 8'($urandom_range(0, 255));
                audio_in_r = 8'($urandom_range(0, 255));
                smp_stb = 1'b1;
                ql.push_back(exp_audio(int'(audio_in_l), m_master, m_left));
                qr.push_back(exp_audio(int'(audio_in_r), m_master, m_right));
            end else begin
                smp_stb = 1'b0;
            end
            @(negedge clk32);
        end
        check("tp.idle", out_stb, 0);

        frame("pre.m", mk(3, 30), 11, 1'b0);
        frame("pre.b", mk(2, 3), 11, 1'b0);
        sample("pre.s", 8'h10, 8'hF0);
        mw_en = 1'b1;
        v = mk(5, 9);
        @(negedge clk32);
        for (int i = 10; i > 4; i--) begin
            mw_data = v[i];
            mw_clk = 1'b0;
            @(negedge clk32);
            mw_clk = 1'b1;
            @(negedge clk32);
        end
        resb = 1'b0;
        mw_clk = 1'b0;
        mw_en = 1'b0;
        #1;
        m_master = 40; m_left = 20; m_right = 20;
        m_bass = 6; m_treble = 6; m_mixer = 1;
        check_regs("midrst");
        check("midrst.outl", audio_out_l, 0);
        check("midrst.outr", audio_out_r, 0);
        check("midrst.ostb", out_stb, 0);
        check("midrst.cstb", cmd_stb, 0);
        repeat (2) @(negedge clk32);
        resb = 1'b1;
        @(negedge clk32);
        frame("post", mk(4, 11), 11, 1'b0);
        sample("post.s", 8'hA0, 8'h60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
